// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared encodings and helpers for the async FIFO read side
package fifo_pkg;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    // Zero-extension does not change the XOR reduction, so any payload up to 64 bits fits.
    function automatic logic parity_calc(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry valid/ready skid buffer, head is always the older word
module fifo_rd_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_push,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic [1:0]            o_count
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_skid;
    logic [1:0]            r_count;
    logic                  r_valid;
    logic                  w_deq;

    assign w_deq   = r_valid & i_ready;
    assign o_data  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;

    always_ff @(posedge Rclk or negedge Rrst) begin
        if (!Rrst) begin
            r_head  <= '0;
            r_skid  <= '0;
            r_count <= CNT_EMPTY;
            r_valid <= 1'b0;
        end else begin
            case (r_count)
                CNT_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_count <= CNT_ONE;
                        r_valid <= 1'b1;
                    end
                end
                CNT_ONE: begin
                    if (i_push && !w_deq) begin
                        r_skid  <= i_data;
                        r_count <= CNT_TWO;
                    end else if (i_push && w_deq) begin
                        r_head  <= i_data;
                    end else if (w_deq) begin
                        r_count <= CNT_EMPTY;
                        r_valid <= 1'b0;
                    end
                end
                CNT_TWO: begin
                    // Upstream never pushes here; a dequeue promotes the skid word.
                    if (w_deq) begin
                        r_head  <= r_skid;
                        r_count <= CNT_ONE;
                    end
                end
                default: begin
                    r_count <= CNT_EMPTY;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_drain.sv
// rtl/fifo_rd_drain.sv - async FIFO read-side drain into a skid buffer; FIFO_RD_PARITY_EN adds parity check
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_ODD    = 0
) (
    input  logic                  Rclk,
    input  logic                  Rrst,
    input  logic                  Rd_en,
    input  logic                  Rempty,
`ifdef FIFO_RD_PARITY_EN
    input  logic [DATA_WIDTH:0]   Rdata,
`else
    input  logic [DATA_WIDTH-1:0] Rdata,
`endif
    output logic                  Rinc,
    output logic [DATA_WIDTH-1:0] Out_data,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output logic [1:0]            Buf_count
`ifdef FIFO_RD_PARITY_EN
    ,
    output logic                  Parity_err
`endif
);

    if (PAR_ODD != 0 && PAR_ODD != 1) begin : g_par_odd_chk
        $error("PAR_ODD must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] w_payload;
    logic [1:0]            w_count;

    // Gated only by registered count, so Out_ready never reaches Rinc combinationally.
    assign Rinc      = Rd_en & ~Rempty & (w_count != CNT_TWO);
    assign w_payload = Rdata[DATA_WIDTH-1:0];
    assign Buf_count = w_count;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .Rclk    (Rclk),
        .Rrst    (Rrst),
        .i_data  (w_payload),
        .i_push  (Rinc),
        .i_ready (Out_ready),
        .o_data  (Out_data),
        .o_valid (Out_valid),
        .o_count (w_count)
    );

`ifdef FIFO_RD_PARITY_EN
    logic r_parity_err;
    logic w_par_bad;

    assign w_par_bad  = Rdata[DATA_WIDTH] != parity_calc(64'(w_payload), 1'(PAR_ODD));
    assign Parity_err = r_parity_err;

    always_ff @(posedge Rclk or negedge Rrst) begin
        if (!Rrst) begin
            r_parity_err <= 1'b0;
        end else if (Rinc && w_par_bad) begin
            r_parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb/tb_fifo_rd_drain.sv - randomized self-checking bench for fifo_rd_drain against a queue model
module tb_fifo_rd_drain;

    localparam int DW      = 8;
    localparam int PAR_ODD = 0;
`ifdef FIFO_RD_PARITY_EN
    localparam int RW = DW + 1;
`else
    localparam int RW = DW;
`endif

    logic          Rclk = 1'b0;
    logic          Rrst = 1'b0;
    logic          Rd_en = 1'b0;
    logic          Rempty = 1'b1;
    logic [RW-1:0] Rdata = '0;
    logic          Rinc;
    logic [DW-1:0] Out_data;
    logic          Out_valid;
    logic          Out_ready = 1'b0;
    logic [1:0]    Buf_count;
`ifdef FIFO_RD_PARITY_EN
    logic          Parity_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [RW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          exp_perr = 1'b0;

    fifo_rd_drain #(
        .DATA_WIDTH (DW),
        .PAR_ODD    (PAR_ODD)
    ) dut (
        .Rclk       (Rclk),
        .Rrst       (Rrst),
        .Rd_en      (Rd_en),
        .Rempty     (Rempty),
        .Rdata      (Rdata),
        .Rinc       (Rinc),
        .Out_data   (Out_data),
        .Out_valid  (Out_valid),
        .Out_ready  (Out_ready),
        .Buf_count  (Buf_count)
`ifdef FIFO_RD_PARITY_EN
        ,
        .Parity_err (Parity_err)
`endif
    );

    always #5 Rclk = ~Rclk;

    function automatic logic [RW-1:0] mk_word(input logic [DW-1:0] d, input logic bad);
        logic [RW-1:0] w;
        w = RW'(d);
`ifdef FIFO_RD_PARITY_EN
        w[DW] = (^d) ^ 1'(PAR_ODD) ^ bad;
`else
        if (bad) w = RW'(d);
`endif
        return w;
    endfunction

    // One clock: present FIFO head, check outputs at negedge, advance the model at posedge.
    task automatic cycle();
        logic          exp_rinc;
        logic          exp_valid;
        logic [RW-1:0] w;
        Rempty = (fifo_q.size() == 0);
        Rdata  = Rempty ? RW'($urandom) : fifo_q[0];
        @(negedge Rclk);
        exp_valid = (exp_q.size() != 0);
        exp_rinc  = Rd_en && !Rempty && (exp_q.size() < 2);
        checks++;
        if (Buf_count !== 2'(exp_q.size())) begin
            errors++; $display("FAIL buf_count got %0d want %0d", Buf_count, exp_q.size());
        end
        checks++;
        if (Out_valid !== exp_valid) begin
            errors++; $display("FAIL out_valid got %b want %b", Out_valid, exp_valid);
        end
        checks++;
        if (Rinc !== exp_rinc) begin
            errors++; $display("FAIL rinc got %b want %b", Rinc, exp_rinc);
        end
        if (exp_valid) begin
            checks++;
            if (Out_data !== exp_q[0]) begin
                errors++; $display("FAIL out_data got %h want %h", Out_data, exp_q[0]);
            end
        end
`ifdef FIFO_RD_PARITY_EN
        checks++;
        if (Parity_err !== exp_perr) begin
            errors++; $display("FAIL parity_err got %b want %b", Parity_err, exp_perr);
        end
`endif
        @(posedge Rclk);
        if (exp_valid && Out_ready) void'(exp_q.pop_front());
        if (exp_rinc) begin
            w = fifo_q.pop_front();
            exp_q.push_back(w[DW-1:0]);
`ifdef FIFO_RD_PARITY_EN
            if ((^w) != 1'(PAR_ODD)) exp_perr = 1'b1;
`endif
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_reset_now();
        Rrst = 1'b0;
        Rempty = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        exp_perr = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (Buf_count !== 2'd0 || Out_valid !== 1'b0 || Out_data !== '0 || Rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got cnt=%0d v=%b d=%h rinc=%b want 0 0 00 0",
                     Buf_count, Out_valid, Out_data, Rinc);
        end
        @(posedge Rclk); #1;
        Rrst = 1'b1;
        Rd_en = 1'b1;
        run(3);
    endtask

    task automatic test_stream();
        Rd_en = 1'b1; Out_ready = 1'b1;
        fifo_q.push_back(mk_word(8'h11, 1'b0));
        fifo_q.push_back(mk_word(8'h22, 1'b0));
        fifo_q.push_back(mk_word(8'h33, 1'b0));
        run(6);
    endtask

    task automatic test_backpressure();
        Rd_en = 1'b1; Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(mk_word(8'hA0 + 8'(i), 1'b0));
        run(4);
        checks++;
        if (fifo_q.size() != 2) begin
            errors++; $display("FAIL backpressure_pops got %0d left want 2", fifo_q.size());
        end
        Out_ready = 1'b1;
        run(6);
    endtask

    task automatic test_pop_deq();
        Rd_en = 1'b1; Out_ready = 1'b1;
        for (int i = 0; i < 6; i++) fifo_q.push_back(mk_word(8'(8'h40 + 8'(3 * i)), 1'b0));
        run(9);
    endtask

    task automatic test_rd_en();
        Rd_en = 1'b1; Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(mk_word(8'hC0 + 8'(i), 1'b0));
        run(3);
        Rd_en = 1'b0; Out_ready = 1'b1;
        run(3);
        Rd_en = 1'b1;
        run(5);
    endtask

    task automatic test_reset_midstream();
        Rd_en = 1'b1; Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) fifo_q.push_back(mk_word(8'h5A ^ 8'(i), 1'b0));
        run(3);
        do_reset_now();
        #1;
        checks++;
        if (Buf_count !== 2'd0 || Out_valid !== 1'b0 || Rinc !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got cnt=%0d v=%b rinc=%b want 0 0 0", Buf_count, Out_valid, Rinc);
        end
        @(posedge Rclk); #1;
        Rrst = 1'b1;
        run(3);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fifo_q.size() < 8)
                fifo_q.push_back(mk_word(8'($urandom), 1'b0));
            Rd_en     = ($urandom_range(0, 5) != 0);
            Out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        Rd_en = 1'b1; Out_ready = 1'b1;
        run(12);
    endtask

`ifdef FIFO_RD_PARITY_EN
    task automatic test_parity();
        Rd_en = 1'b1; Out_ready = 1'b1;
        fifo_q.push_back(mk_word(8'h55, 1'b0));
        fifo_q.push_back({1'b1, 8'h03});
        fifo_q.push_back(mk_word(8'h77, 1'b0));
        fifo_q.push_back(mk_word(8'h0F, 1'b0));
        run(7);
        checks++;
        if (exp_perr !== 1'b1 || Parity_err !== 1'b1) begin
            errors++; $display("FAIL parity_sticky got %b want 1", Parity_err);
        end
        do_reset_now();
        #1;
        checks++;
        if (Parity_err !== 1'b0) begin
            errors++; $display("FAIL parity_reset got %b want 0", Parity_err);
        end
        @(posedge Rclk); #1;
        Rrst = 1'b1;
        run(2);
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_pop_deq();
        test_rd_en();
        test_reset_midstream();
`ifdef FIFO_RD_PARITY_EN
        test_parity();
`endif
        test_random();
        checks++;
        if (exp_q.size() != 0 || fifo_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain got fifo=%0d buf=%0d want 0 0", fifo_q.size(), exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
